hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameters SHALL be, one per line:
- CNT_W, 32, width of stall_cycles counter
- FLUSH_CNT_W, 16, width of flush_count counter
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in ID
- ifid_use_rs1, ifid_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- idex_rd  in  5  destination of the instruction in EX
- idex_mem_read  in  1  EX instruction is a load
- branch_taken  in  1  EX resolved a taken branch or jump; PC redirect this cycle
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  in  1  MEM-stage instruction has an outstanding data access
- dmem_ready  in  1  data access completes this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  load NOP into IF/ID
- idex_flush  out  1  load NOP (bubble) into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB; MEM/WB write-enable low
- state_o  out  2  current FSM state
- stall_cycles  out  CNT_W  cycles with pc_stall high
- flush_count  out  FLUSH_CNT_W  taken-branch flush events

Function
REQ-003 FSM states SHALL be RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3; the state is registered, outputs are combinational from the state and the current inputs.
REQ-004 Load-use hazard SHALL be: idex_mem_read & idex_rd!=0 & ((ifid_use_rs1 & ifid_rs1==idex_rd) | (ifid_use_rs2 & ifid_rs2==idex_rd)).
REQ-005 RUN, priority 1: dmem_req & !dmem_ready SHALL assert pc_stall, ifid_stall and pipe_freeze, and set next state MEM_WAIT; branch_taken and the hazard are ignored that cycle.
REQ-006 RUN, priority 2: branch_taken SHALL assert ifid_flush and idex_flush; next state is FLUSH if !imem_ready, else RUN; flush_count increments.
REQ-007 RUN, priority 3: a load-use hazard SHALL assert pc_stall, ifid_stall and idex_flush; next state LOAD_STALL.
REQ-008 RUN, priority 4: !imem_ready SHALL assert pc_stall and ifid_flush; next state RUN.
REQ-009 LOAD_STALL SHALL last exactly one cycle and apply REQ-005/006/008 with load-use detection masked; default next state RUN.
REQ-010 MEM_WAIT SHALL keep pc_stall, ifid_stall and pipe_freeze asserted while !dmem_ready, and ignore branch_taken; on dmem_ready it SHALL drop all outputs that cycle and go to RUN.
REQ-011 FLUSH SHALL assert ifid_flush and pc_stall while !imem_ready, discarding the stale fetch; on imem_ready it SHALL drop both and go to RUN.
REQ-012 stall_cycles SHALL increment in every cycle pc_stall=1 and saturate at all-ones.
REQ-013 flush_count SHALL saturate at all-ones.
REQ-014 ifid_stall and ifid_flush SHALL never be high together; flush wins on conflict.

Reset
REQ-015 rst_n low SHALL force state RUN and zero both counters immediately, independent of clk.
REQ-016 During reset, all stall, flush and freeze outputs SHALL be 0 and state_o SHALL be 0.
REQ-017 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL abandon the wait; no stall SHALL persist after release.

Structure
REQ-018 A shared package hazard_pkg SHALL hold the state enum (2-bit) and the default counter-width constants.
REQ-019 The combinational load-use compare SHALL be a sub-module load_use_detect; the FSM and counters SHALL stay in hazard_controller.

Verification
REQ-020 Load x5 in EX (idex_mem_read=1, idex_rd=5), ID ifid_rs2=5, ifid_use_rs2=1 -> one cycle of pc_stall=ifid_stall=idex_flush=1; state 1 then 0; stall_cycles=1.
REQ-021 idex_rd=0 with idex_mem_read=1 and ifid_rs1=0 -> no stall.
REQ-022 dmem_req=1, dmem_ready low for 3 cycles then high -> pipe_freeze high exactly 3 cycles; branch_taken pulsed during the wait has no effect; stall_cycles=3.
REQ-023 branch_taken with imem_ready=0 for 2 cycles -> cycle 0 ifid_flush=idex_flush=1; cycles 1-2 state 3 with ifid_flush=1; flush_count=1.
REQ-024 Simultaneous dmem miss, branch_taken and load-use in RUN -> only the freeze response occurs; next state 2.
REQ-025 rst_n low mid-MEM_WAIT -> outputs 0 and counters 0 asynchronously; after release, state 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   state_e          - 2-bit FSM state encoding (RUN, LOAD_STALL, MEM_WAIT, FLUSH)
//   DEF_CNT_W        - default width of the stall-cycle counter
//   DEF_FLUSH_CNT_W  - default width of the branch-flush counter
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_FLUSH      = 2'd3
  } state_e;

  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_FLUSH_CNT_W = 16;

endpackage : hazard_pkg

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard compare between the instruction in ID
// and a load in EX.
// Ports:
//   ifid_rs1/ifid_rs2          in  source registers of the ID instruction
//   ifid_use_rs1/ifid_use_rs2  in  ID instruction actually reads rs1/rs2
//   idex_rd                    in  destination of the EX instruction
//   idex_mem_read              in  EX instruction is a load
//   hazard                     out ID needs a value the EX load has not produced
// ---------------------------------------------------------------------------
module load_use_detect (
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_use_rs1,
  input  logic       ifid_use_rs2,
  input  logic [4:0] idex_rd,
  input  logic       idex_mem_read,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = ifid_use_rs1 && (ifid_rs1 == idex_rd);
  assign rs2_match = ifid_use_rs2 && (ifid_rs2 == idex_rd);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard = idex_mem_read && (idex_rd != 5'd0) && (rs1_match || rs2_match);

endmodule : load_use_detect

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Five-stage pipeline hazard controller: load-use stalls, data-memory wait
// freezes, taken-branch flushes and instruction-fetch misses. The state is
// registered; all control outputs are combinational from state and inputs.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ifid_*, idex_*             operand/destination info for load-use detection
//   branch_taken               EX redirects the PC this cycle
//   imem_ready                 fetch data valid this cycle
//   dmem_req, dmem_ready       MEM-stage access outstanding / completing
//   pc_stall, ifid_stall       hold PC / hold IF/ID
//   ifid_flush, idex_flush     load NOP into IF/ID / bubble into ID/EX
//   pipe_freeze                hold ID/EX, EX/MEM, MEM/WB (MEM/WB WE low)
//   state_o                    current FSM state
//   stall_cycles, flush_count  saturating event counters
// ---------------------------------------------------------------------------
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned FLUSH_CNT_W = DEF_FLUSH_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             ifid_rs1,
  input  logic [4:0]             ifid_rs2,
  input  logic                   ifid_use_rs1,
  input  logic                   ifid_use_rs2,
  input  logic [4:0]             idex_rd,
  input  logic                   idex_mem_read,
  input  logic                   branch_taken,
  input  logic                   imem_ready,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  output logic                   pc_stall,
  output logic                   ifid_stall,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   pipe_freeze,
  output logic [1:0]             state_o,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       stall_cycles_q, stall_cycles_d;
  logic [FLUSH_CNT_W-1:0] flush_count_q, flush_count_d;

  logic load_use;
  logic dmem_miss;
  logic flush_inc;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_flush_c, pipe_freeze_c;

  load_use_detect u_load_use_detect (
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_use_rs1  (ifid_use_rs1),
    .ifid_use_rs2  (ifid_use_rs2),
    .idex_rd       (idex_rd),
    .idex_mem_read (idex_mem_read),
    .hazard        (load_use)
  );

  assign dmem_miss = dmem_req && !dmem_ready;

  // NOTE: every signal assigned here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    flush_inc     = 1'b0;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    pipe_freeze_c = 1'b0;

    unique case (state_q)
      // LOAD_STALL shares RUN's priority chain but cannot re-detect the same
      // load: the bubble it inserted already resolved the dependency.
      ST_RUN, ST_LOAD_STALL: begin
        state_d = ST_RUN;
        if (dmem_miss) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          pipe_freeze_c = 1'b1;
          state_d       = ST_MEM_WAIT;
        end else if (branch_taken) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          flush_inc    = 1'b1;
          state_d      = imem_ready ? ST_RUN : ST_FLUSH;
        end else if (load_use && (state_q == ST_RUN)) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_flush_c = 1'b1;
          state_d      = ST_LOAD_STALL;
        end else if (!imem_ready) begin
          pc_stall_c   = 1'b1;
          ifid_flush_c = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_stall_c    = 1'b1;
          ifid_stall_c  = 1'b1;
          pipe_freeze_c = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end

      // The fetch in flight at redirect time belongs to the wrong path; keep
      // discarding until the redirected fetch returns.
      ST_FLUSH: begin
        if (!imem_ready) begin
          pc_stall_c   = 1'b1;
          ifid_flush_c = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase

    // A flush overrides a hold of IF/ID: the held contents would be discarded.
    if (ifid_flush_c) begin
      ifid_stall_c = 1'b0;
    end
  end

  // Outputs are forced quiet while reset is asserted, regardless of inputs.
  assign pc_stall    = rst_n && pc_stall_c;
  assign ifid_stall  = rst_n && ifid_stall_c;
  assign ifid_flush  = rst_n && ifid_flush_c;
  assign idex_flush  = rst_n && idex_flush_c;
  assign pipe_freeze = rst_n && pipe_freeze_c;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (pc_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (flush_inc && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + FLUSH_CNT_W'(1);
    end
  end

  // NOTE: the reset branch is asynchronous so a hung wait is abandoned the
  // instant rst_n falls; state uses non-blocking assignments so every flop
  // samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign state_o      = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule : hazard_controller

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
// Self-checking bench for hazard_controller. A second, narrow-counter
// instance shares the stimulus so counter saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       mem_read;
    logic       branch;
    logic       imem_ready;
    logic       dmem_req;
    logic       dmem_ready;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [4:0] out;   // {pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze}
    logic [1:0] nxt;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] out;
    logic [1:0] st;
  } exp_t;

  localparam logic [4:0] O_NONE = 5'b00000;
  localparam logic [4:0] O_LU   = 5'b11010;
  localparam logic [4:0] O_BR   = 5'b00110;
  localparam logic [4:0] O_FRZ  = 5'b11001;
  localparam logic [4:0] O_IMS  = 5'b10100;

  localparam int unsigned SAT_STALL_MAX = 7;
  localparam int unsigned SAT_FLUSH_MAX = 3;

  logic       clk;
  logic       rst_n;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       ifid_use_rs1, ifid_use_rs2, idex_mem_read;
  logic       branch_taken, imem_ready, dmem_req, dmem_ready;

  logic        pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze;
  logic [1:0]  state_o;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  logic        s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_flush, s_pipe_freeze;
  logic [1:0]  s_state_o;
  logic [2:0]  s_stall_cycles;
  logic [1:0]  s_flush_count;

  int checks   = 0;
  int failures = 0;

  int unsigned exp_stall, exp_flush, exp_sat_stall, exp_sat_flush;

  exp_t sb[$];
  vec_t vecs[$];

  hazard_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_use_rs1  (ifid_use_rs1),
    .ifid_use_rs2  (ifid_use_rs2),
    .idex_rd       (idex_rd),
    .idex_mem_read (idex_mem_read),
    .branch_taken  (branch_taken),
    .imem_ready    (imem_ready),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .pc_stall      (pc_stall),
    .ifid_stall    (ifid_stall),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .pipe_freeze   (pipe_freeze),
    .state_o       (state_o),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  hazard_controller #(.CNT_W(3), .FLUSH_CNT_W(2)) u_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_use_rs1  (ifid_use_rs1),
    .ifid_use_rs2  (ifid_use_rs2),
    .idex_rd       (idex_rd),
    .idex_mem_read (idex_mem_read),
    .branch_taken  (branch_taken),
    .imem_ready    (imem_ready),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .pc_stall      (s_pc_stall),
    .ifid_stall    (s_ifid_stall),
    .ifid_flush    (s_ifid_flush),
    .idex_flush    (s_idex_flush),
    .pipe_freeze   (s_pipe_freeze),
    .state_o       (s_state_o),
    .stall_cycles  (s_stall_cycles),
    .flush_count   (s_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic [4:0] rd,
                             input logic mr, input logic br, input logic ir,
                             input logic dq, input logic dr);
    in_t x;
    x.rs1 = rs1; x.rs2 = rs2; x.use1 = u1; x.use2 = u2; x.rd = rd;
    x.mem_read = mr; x.branch = br; x.imem_ready = ir;
    x.dmem_req = dq; x.dmem_ready = dr;
    return x;
  endfunction

  task automatic apply(input in_t x);
    ifid_rs1      = x.rs1;
    ifid_rs2      = x.rs2;
    ifid_use_rs1  = x.use1;
    ifid_use_rs2  = x.use2;
    idex_rd       = x.rd;
    idex_mem_read = x.mem_read;
    branch_taken  = x.branch;
    imem_ready    = x.imem_ready;
    dmem_req      = x.dmem_req;
    dmem_ready    = x.dmem_ready;
  endtask

  function automatic logic [4:0] outs();
    return {pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze};
  endfunction

  function automatic logic [4:0] s_outs();
    return {s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_flush, s_pipe_freeze};
  endfunction

  // One clock cycle: drive after the rising edge, sample at the falling edge.
  task automatic step(input string name, input in_t x, input logic [4:0] out,
                      input logic [1:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    apply(x);
    e.name = name; e.out = out; e.st = st;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, " outs"},  32'(outs()),   32'(e.out));
    check({e.name, " state"}, 32'(state_o),  32'(e.st));
    check({e.name, " excl"},  32'(ifid_stall & ifid_flush), 32'd0);
    check({e.name, " sat_outs"}, 32'(s_outs()), 32'(e.out));
    check({e.name, " stall_cycles"}, stall_cycles, exp_stall);
    check({e.name, " flush_count"},  32'(flush_count), exp_flush);
    check({e.name, " sat_stall"}, 32'(s_stall_cycles), exp_sat_stall);
    check({e.name, " sat_flush"}, 32'(s_flush_count),  exp_sat_flush);
    if (e.out[4]) begin
      exp_stall++;
      if (exp_sat_stall < SAT_STALL_MAX) exp_sat_stall++;
    end
    if (e.out[2] && e.out[1]) begin
      exp_flush++;
      if (exp_sat_flush < SAT_FLUSH_MAX) exp_sat_flush++;
    end
  endtask

  task automatic check_reset_quiet(input string name);
    check({name, " outs"},  32'(outs()),  32'd0);
    check({name, " state"}, 32'(state_o), 32'd0);
    check({name, " stall_cycles"}, stall_cycles, 32'd0);
    check({name, " flush_count"},  32'(flush_count), 32'd0);
    check({name, " sat_stall"}, 32'(s_stall_cycles), 32'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string name, input in_t hold);
    @(negedge clk);
    #1;
    apply(hold);
    rst_n = 1'b0;
    #1;
    check_reset_quiet(name);
    exp_stall = 0; exp_flush = 0; exp_sat_stall = 0; exp_sat_flush = 0;
    @(negedge clk);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    rst_n = 1'b1;
  endtask

  initial begin
    in_t neutral, lu, lu5, imiss, br, br_nr, miss, mwait, mdone;

    neutral = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    lu      = mk(7, 3, 1, 0, 7, 1, 0, 1, 0, 1);
    lu5     = mk(2, 5, 0, 1, 5, 1, 0, 1, 0, 1);
    imiss   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    br      = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    br_nr   = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    miss    = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    mwait   = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    mdone   = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);

    exp_stall = 0; exp_flush = 0; exp_sat_stall = 0; exp_sat_flush = 0;

    vecs.push_back('{"idle",         neutral,                             O_NONE, 2'd0});
    vecs.push_back('{"lu_rs1",       lu,                                  O_LU,   2'd1});
    vecs.push_back('{"lu_rs2",       lu5,                                 O_LU,   2'd1});
    vecs.push_back('{"rd_zero",      mk(0, 0, 1, 1, 0, 1, 0, 1, 0, 1),   O_NONE, 2'd0});
    vecs.push_back('{"no_use",       mk(7, 7, 0, 0, 7, 1, 0, 1, 0, 1),   O_NONE, 2'd0});
    vecs.push_back('{"not_load",     mk(7, 7, 1, 1, 7, 0, 0, 1, 0, 1),   O_NONE, 2'd0});
    vecs.push_back('{"rd_differs",   mk(6, 8, 1, 1, 7, 1, 0, 1, 0, 1),   O_NONE, 2'd0});
    vecs.push_back('{"branch_rdy",   br,                                  O_BR,   2'd0});
    vecs.push_back('{"branch_nrdy",  br_nr,                               O_BR,   2'd3});
    vecs.push_back('{"imem_miss",    imiss,                               O_IMS,  2'd0});
    vecs.push_back('{"dmem_miss",    miss,                                O_FRZ,  2'd2});
    vecs.push_back('{"dmem_hit",     mdone,                               O_NONE, 2'd0});
    vecs.push_back('{"all_at_once",  mk(7, 0, 1, 0, 7, 1, 1, 0, 1, 0),   O_FRZ,  2'd2});
    vecs.push_back('{"br_over_lu",   mk(7, 0, 1, 0, 7, 1, 1, 1, 0, 1),   O_BR,   2'd0});
    vecs.push_back('{"lu_over_imiss", mk(7, 0, 1, 0, 7, 1, 0, 0, 0, 1),  O_LU,   2'd1});

    // Reset: outputs quiet even with active hazard inputs.
    rst_n = 1'b0;
    apply(mk(7, 0, 1, 0, 7, 1, 1, 0, 1, 0));
    #2;
    check_reset_quiet("reset_async");
    @(posedge clk);
    #1;
    check_reset_quiet("reset_clocked");
    @(negedge clk);
    apply(neutral);
    rst_n = 1'b1;

    // Single-cycle responses from RUN, each followed by a neutral cycle that
    // shows the next state and returns the FSM to RUN.
    foreach (vecs[i]) begin
      step(vecs[i].name, vecs[i].in, vecs[i].out, 2'd0);
      step({vecs[i].name, "_next"}, neutral, O_NONE, vecs[i].nxt);
    end

    // Load-use: one stall cycle, hazard masked in LOAD_STALL, back to RUN.
    pulse_reset("reset_pre_lu", neutral);
    step("lu5_c0",   lu5,     O_LU,   2'd0);
    step("lu5_c1",   lu5,     O_NONE, 2'd1);
    step("lu5_c2",   neutral, O_NONE, 2'd0);
    check("lu5 stall_cycles", stall_cycles, 32'd1);

    // LOAD_STALL still honours the remaining priorities.
    step("ls_br_c0",  lu, O_LU, 2'd0);
    step("ls_br_c1",  mk(7, 0, 1, 0, 7, 1, 1, 1, 0, 1), O_BR, 2'd1);
    step("ls_br_c2",  neutral, O_NONE, 2'd0);
    step("ls_mis_c0", lu, O_LU, 2'd0);
    step("ls_mis_c1", mk(7, 0, 1, 0, 7, 1, 1, 1, 1, 0), O_FRZ, 2'd1);
    step("ls_mis_c2", mdone, O_NONE, 2'd2);
    step("ls_mis_c3", neutral, O_NONE, 2'd0);
    step("ls_im_c0",  lu, O_LU, 2'd0);
    step("ls_im_c1",  mk(7, 0, 1, 0, 7, 1, 0, 0, 0, 1), O_IMS, 2'd1);
    step("ls_im_c2",  neutral, O_NONE, 2'd0);

    // Three-cycle data wait, branch pulsed mid-wait is ignored.
    pulse_reset("reset_pre_mw", neutral);
    step("mw_c0", miss,    O_FRZ,  2'd0);
    step("mw_c1", mwait,   O_FRZ,  2'd2);
    step("mw_c2", miss,    O_FRZ,  2'd2);
    step("mw_c3", mdone,   O_NONE, 2'd2);
    step("mw_c4", neutral, O_NONE, 2'd0);
    check("mw stall_cycles", stall_cycles, 32'd3);
    check("mw flush_count",  32'(flush_count), 32'd0);

    // Branch with a slow redirected fetch.
    pulse_reset("reset_pre_fl", neutral);
    step("fl_c0", br_nr,   O_BR,   2'd0);
    step("fl_c1", imiss,   O_IMS,  2'd3);
    step("fl_c2", imiss,   O_IMS,  2'd3);
    step("fl_c3", neutral, O_NONE, 2'd3);
    step("fl_c4", neutral, O_NONE, 2'd0);
    check("fl flush_count",  32'(flush_count), 32'd1);
    check("fl stall_cycles", stall_cycles, 32'd2);

    // Reset in the middle of MEM_WAIT and of FLUSH abandons the wait.
    step("rmw_c0", miss, O_FRZ, 2'd0);
    step("rmw_c1", miss, O_FRZ, 2'd2);
    pulse_reset("reset_mid_mw", miss);
    step("rmw_after", neutral, O_NONE, 2'd0);
    step("rfl_c0", br_nr, O_BR,  2'd0);
    step("rfl_c1", imiss, O_IMS, 2'd3);
    pulse_reset("reset_mid_fl", imiss);
    step("rfl_after", neutral, O_NONE, 2'd0);

    // Saturation of the narrow instance's counters.
    for (int i = 0; i < 10; i++) step("sat_stall", imiss, O_IMS, 2'd0);
    for (int i = 0; i < 5; i++)  step("sat_flush", br, O_BR, 2'd0);
    step("sat_end", neutral, O_NONE, 2'd0);
    check("sat wide stall",   stall_cycles, 32'd10);
    check("sat wide flush",   32'(flush_count), 32'd5);
    check("sat narrow stall", 32'(s_stall_cycles), 32'd7);
    check("sat narrow flush", 32'(s_flush_count), 32'd3);

    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_controller
